// File: rtl/snake_body_buffer.sv
// snake_body_buffer
// -----------------
// Holds up to MAX_LEN {x,y} snake body segments. Index 0 is the head.
// A new head arrives through a valid/ready handshake. The buffer then scans
// the body for a self-collision, one segment per cycle. After the scan it
// either commits the move (shift, with optional grow) or rejects it with hit.
//
// Optional feature, selected by the macro SNAKE_BOUNDS_CHECK_EN: a head
// outside the playfield (x > XSCREEN-SEG or y > YSCREEN-SEG) is rejected in
// the same way as a self-hit.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   init                load the initial snake (has priority over a step)
//   step_valid/ready    new-head handshake (ready only in IDLE)
//   head_x_in/head_y_in requested head position
//   grow                lengthen by one on commit (sampled with the step)
//   done                one-cycle pulse when a step completes
//   hit                 valid with done; 1 = step rejected
//   tail_valid          valid with done; tail_x/tail_y must be erased
//   tail_x/tail_y       vacated tail position
//   len, full           current segment count; len == MAX_LEN
//   rd_idx/rd_x/rd_y    combinational random-access read (0 beyond len)
module snake_body_buffer #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int X0       = 80,
    parameter int Y0       = 30,
    parameter int SEG      = 10,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic                         step_valid,
    output logic                         step_ready,
    input  logic [XW-1:0]                head_x_in,
    input  logic [YW-1:0]                head_y_in,
    input  logic                         grow,
    output logic                         done,
    output logic                         hit,
    output logic                         tail_valid,
    output logic [XW-1:0]                tail_x,
    output logic [YW-1:0]                tail_y,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         full,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_idx,
    output logic [XW-1:0]                rd_x,
    output logic [YW-1:0]                rd_y
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);

`ifdef SNAKE_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] ent_x_q [MAX_LEN];
    logic [XW-1:0] ent_x_d [MAX_LEN];
    logic [YW-1:0] ent_y_q [MAX_LEN];
    logic [YW-1:0] ent_y_d [MAX_LEN];
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [XW-1:0] hx_q, hx_d;
    logic [YW-1:0] hy_q, hy_d;
    logic          grow_q, grow_d;
    logic          hit_q, hit_d;
    logic          tv_q, tv_d;
    logic [XW-1:0] tx_q, tx_d;
    logic [YW-1:0] ty_q, ty_d;

    // Scan datapath
    logic [LW-1:0] lim;
    logic [LW-1:0] last_idx;
    logic [LW:0]   idx_nx;
    logic          last;
    logic [XW-1:0] sel_x, old_tail_x;
    logic [YW-1:0] sel_y, old_tail_y;
    logic          match, oob, hit_now;

    // Without grow the tail vacates this move, so it is excluded from the scan.
    assign lim      = grow_q ? len_q : len_q - 1'b1;
    assign last_idx = len_q - 1'b1;
    assign idx_nx   = {1'b0, idx_q} + 1'b1;
    // A zero-length scan (grow=0, len=1) still spends its one SCAN cycle.
    assign last     = (idx_nx >= {1'b0, lim});

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        old_tail_x = '0;
        old_tail_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LW'(i)) begin
                sel_x = ent_x_q[i];
                sel_y = ent_y_q[i];
            end
            if (last_idx == LW'(i)) begin
                old_tail_x = ent_x_q[i];
                old_tail_y = ent_y_q[i];
            end
        end
    end

    assign match   = (idx_q < lim) && (sel_x == hx_q) && (sel_y == hy_q);
    assign oob     = BOUNDS_EN && (idx_q == '0) &&
                     ((int'(hx_q) > XSCREEN - SEG) || (int'(hy_q) > YSCREEN - SEG));
    assign hit_now = hit_q | match | oob;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        grow_d  = grow_q;
        hit_d   = hit_q;
        tv_d    = tv_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        for (int i = 0; i < MAX_LEN; i++) begin
            ent_x_d[i] = ent_x_q[i];
            ent_y_d[i] = ent_y_q[i];
        end

        case (state_q)
            IDLE: begin
                if (step_valid) begin
                    hx_d    = head_x_in;
                    hy_d    = head_y_in;
                    grow_d  = grow;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    tv_d    = 1'b0;
                    // An empty buffer has nothing to scan or shift.
                    state_d = (len_q == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                hit_d = hit_now;
                idx_d = idx_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    if (!hit_now) begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            ent_x_d[i] = ent_x_q[i-1];
                            ent_y_d[i] = ent_y_q[i-1];
                        end
                        ent_x_d[0] = hx_q;
                        ent_y_d[0] = hy_q;
                        if (grow_q && (len_q < LW'(MAX_LEN))) begin
                            len_d = len_q + 1'b1;
                            tv_d  = 1'b0;
                        end else begin
                            // Growth at full is ignored, so the tail still moves.
                            tv_d = 1'b1;
                            tx_d = old_tail_x;
                            ty_d = old_tail_y;
                        end
                    end else begin
                        tv_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                tv_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // init aborts anything in flight and swallows a step offered with it.
        if (init) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    ent_x_d[i] = XW'(X0);
                    ent_y_d[i] = YW'(Y0 + i * SEG);
                end else begin
                    ent_x_d[i] = '0;
                    ent_y_d[i] = '0;
                end
            end
            len_d   = LW'(INIT_LEN);
            idx_d   = '0;
            hit_d   = 1'b0;
            tv_d    = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            hx_q    <= '0;
            hy_q    <= '0;
            grow_q  <= 1'b0;
            hit_q   <= 1'b0;
            tv_q    <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                ent_x_q[i] <= '0;
                ent_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            grow_q  <= grow_d;
            hit_q   <= hit_d;
            tv_q    <= tv_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            for (int i = 0; i < MAX_LEN; i++) begin
                ent_x_q[i] <= ent_x_d[i];
                ent_y_q[i] <= ent_y_d[i];
            end
        end
    end

    // Outputs and read port
    assign step_ready = (state_q == IDLE);
    assign done       = (state_q == DONE);
    assign hit        = (state_q == DONE) && hit_q;
    assign tail_valid = tv_q;
    assign tail_x     = tx_q;
    assign tail_y     = ty_q;
    assign len        = len_q;
    assign full       = (len_q == LW'(MAX_LEN));

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((rd_idx == IW'(i)) && (LW'(i) < len_q)) begin
                rd_x = ent_x_q[i];
                rd_y = ent_y_q[i];
            end
        end
    end

endmodule

// File: tb/tb_snake_body_buffer.sv
module tb_snake_body_buffer;

    logic       clk;
    logic       reset;

    // Default-parameter instance
    logic       init, step_valid, step_ready, grow;
    logic [7:0] head_x_in;
    logic [6:0] head_y_in;
    logic       done, hit, tail_valid, full;
    logic [7:0] tail_x, rd_x;
    logic [6:0] tail_y, rd_y;
    logic [4:0] len;
    logic [3:0] rd_idx;

    // MAX_LEN = 5 instance
    logic       b_init, b_step_valid, b_step_ready, b_grow;
    logic [7:0] b_head_x_in;
    logic [6:0] b_head_y_in;
    logic       b_done, b_hit, b_tail_valid, b_full;
    logic [7:0] b_tail_x, b_rd_x;
    logic [6:0] b_tail_y, b_rd_y;
    logic [2:0] b_len;
    logic [2:0] b_rd_idx;

    int checks = 0;
    int errors = 0;

    snake_body_buffer u_dut (
        .clk(clk), .reset(reset), .init(init),
        .step_valid(step_valid), .step_ready(step_ready),
        .head_x_in(head_x_in), .head_y_in(head_y_in), .grow(grow),
        .done(done), .hit(hit), .tail_valid(tail_valid),
        .tail_x(tail_x), .tail_y(tail_y), .len(len), .full(full),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
    );

    snake_body_buffer #(.MAX_LEN(5)) u_dut5 (
        .clk(clk), .reset(reset), .init(b_init),
        .step_valid(b_step_valid), .step_ready(b_step_ready),
        .head_x_in(b_head_x_in), .head_y_in(b_head_y_in), .grow(b_grow),
        .done(b_done), .hit(b_hit), .tail_valid(b_tail_valid),
        .tail_x(b_tail_x), .tail_y(b_tail_y), .len(b_len), .full(b_full),
        .rd_idx(b_rd_idx), .rd_x(b_rd_x), .rd_y(b_rd_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input int idx, input int ex, input int ey);
        rd_idx = 4'(idx);
        #1;
        chk({tag, "_x"}, 32'(rd_x), 32'(ex));
        chk({tag, "_y"}, 32'(rd_y), 32'(ey));
    endtask

    task automatic chk_init_pattern(input string tag);
        chk_rd({tag, "0"}, 0, 80, 30);
        chk_rd({tag, "1"}, 1, 80, 40);
        chk_rd({tag, "2"}, 2, 80, 50);
        chk_rd({tag, "3"}, 3, 80, 60);
        chk({tag, "_len"}, 32'(len), 4);
    endtask

    // Issue a step on the default instance; n counts edges from the accept edge
    // up to and including the edge that raises done.
    task automatic do_step(input string tag, input int x, input int y, input logic g,
                           input int exp_lat, input logic exp_hit, input logic exp_tv,
                           input int exp_tx, input int exp_ty);
        int n;
        chk({tag, "_ready"}, 32'(step_ready), 1);
        head_x_in  = 8'(x);
        head_y_in  = 7'(y);
        grow       = g;
        step_valid = 1'b1;
        n = 0;
        do begin
            tick();
            step_valid = 1'b0;
            n++;
        end while (!done && n < 40);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        chk({tag, "_tv"},  32'(tail_valid), 32'(exp_tv));
        if (exp_tv) begin
            chk({tag, "_tx"}, 32'(tail_x), 32'(exp_tx));
            chk({tag, "_ty"}, 32'(tail_y), 32'(exp_ty));
        end
        tick();
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_ready_back"}, 32'(step_ready), 1);
    endtask

    task automatic do_step_b(input string tag, input int x, input int y, input logic g,
                             input int exp_lat, input logic exp_hit, input logic exp_tv,
                             input int exp_tx, input int exp_ty);
        int n;
        b_head_x_in  = 8'(x);
        b_head_y_in  = 7'(y);
        b_grow       = g;
        b_step_valid = 1'b1;
        n = 0;
        do begin
            tick();
            b_step_valid = 1'b0;
            n++;
        end while (!b_done && n < 40);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(b_hit), 32'(exp_hit));
        chk({tag, "_tv"},  32'(b_tail_valid), 32'(exp_tv));
        if (exp_tv) begin
            chk({tag, "_tx"}, 32'(b_tail_x), 32'(exp_tx));
            chk({tag, "_ty"}, 32'(b_tail_y), 32'(exp_ty));
        end
        tick();
    endtask

    initial begin
        int seen_done;
        reset = 1'b1;
        init = 1'b0; step_valid = 1'b0; grow = 1'b0;
        head_x_in = '0; head_y_in = '0; rd_idx = '0;
        b_init = 1'b0; b_step_valid = 1'b0; b_grow = 1'b0;
        b_head_x_in = '0; b_head_y_in = '0; b_rd_idx = '0;
        tick();
        tick();

        // Reset state
        chk("rst_len", 32'(len), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_tv", 32'(tail_valid), 0);
        chk("rst_tx", 32'(tail_x), 0);
        chk("rst_ty", 32'(tail_y), 0);
        chk("rst_full", 32'(full), 0);
        chk_rd("rst_rd0", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(step_ready), 1);

        // Empty buffer: straight to DONE, nothing committed
        do_step("empty", 5, 5, 1'b0, 1, 1'b0, 1'b0, 0, 0);
        chk("empty_len", 32'(len), 0);

        // Init pattern and read port beyond len
        do_init();
        chk_init_pattern("init");
        chk("init_full", 32'(full), 0);
        chk_rd("init_rd5", 5, 0, 0);

        // Plain move
        do_step("mv", 90, 30, 1'b0, 4, 1'b0, 1'b1, 80, 60);
        chk_rd("mv0", 0, 90, 30);
        chk_rd("mv1", 1, 80, 30);
        chk_rd("mv2", 2, 80, 40);
        chk_rd("mv3", 3, 80, 50);
        chk("mv_len", 32'(len), 4);

        // Moving onto the vacating tail is legal
        do_init();
        do_step("tl", 80, 60, 1'b0, 4, 1'b0, 1'b1, 80, 60);
        chk_rd("tl0", 0, 80, 60);
        chk_rd("tl3", 3, 80, 50);

        // Same target with grow: tail stays, so it is a hit
        do_init();
        do_step("tlg", 80, 60, 1'b1, 5, 1'b1, 1'b0, 0, 0);
        chk_init_pattern("tlg");

        // Grow on default instance
        do_init();
        do_step("gr", 90, 30, 1'b1, 5, 1'b0, 1'b0, 0, 0);
        chk("gr_len", 32'(len), 5);
        chk_rd("gr4", 4, 80, 60);

        // init during SCAN aborts the step
        do_init();
        head_x_in = 8'd90; head_y_in = 7'd30; grow = 1'b0;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("abort_ready", 32'(step_ready), 1);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen_done++;
            tick();
        end
        chk("abort_nodone", 32'(seen_done), 0);
        chk_init_pattern("abort");

        // Out-of-range head
        do_init();
`ifdef SNAKE_BOUNDS_CHECK_EN
        do_step("oob", 151, 30, 1'b0, 4, 1'b1, 1'b0, 0, 0);
        chk_rd("oob0", 0, 80, 30);
`else
        do_step("oob", 151, 30, 1'b0, 4, 1'b0, 1'b1, 80, 60);
        chk_rd("oob0", 0, 151, 30);
`endif

        // MAX_LEN = 5: grow to full, then grow at full behaves like a move
        b_init = 1'b1;
        tick();
        b_init = 1'b0;
        chk("b_init_len", 32'(b_len), 4);
        do_step_b("b_g1", 90, 30, 1'b1, 5, 1'b0, 1'b0, 0, 0);
        chk("b_g1_len", 32'(b_len), 5);
        chk("b_g1_full", 32'(b_full), 1);
        do_step_b("b_g2", 100, 30, 1'b1, 6, 1'b0, 1'b1, 80, 60);
        chk("b_g2_len", 32'(b_len), 5);
        chk("b_g2_full", 32'(b_full), 1);
        b_rd_idx = 3'd0;
        #1;
        chk("b_rd0_x", 32'(b_rd_x), 100);
        b_rd_idx = 3'd4;
        #1;
        chk("b_rd4_x", 32'(b_rd_x), 80);
        chk("b_rd4_y", 32'(b_rd_y), 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
